// File: rtl/rob_retire_ctrl.sv
// ---------------------------------------------------------------------------
// rob_retire_ctrl
//   Reorder-buffer occupancy and retirement controller. It tracks head, tail
//   and count for a circular ROB, grants one allocation per cycle, and retires
//   up to two of the oldest entries per cycle, strictly in order. A flush
//   empties the ROB and holds dispatch for the flush cycle plus one more.
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_RUN   | normal operation: allocate at tail, retire from head
//   ST_FLUSH | one-cycle recovery after a flush; pointers held at 0, no
//            | grants and no retires
//
// Ports
//   clk            in   clock; all state updates on its rising edge
//   rstn           in   asynchronous active-low reset
//   alloc_req      in   dispatch requests one ROB entry
//   entry_complete in   per-slot complete flags [DEPTH]
//   retire_en      in   retirement sink can accept retirements this cycle
//   flush          in   discard all ROB contents
//   alloc_gnt      out  allocation accepted this cycle
//   alloc_idx      out  slot written on grant (always the tail)
//   stall          out  dispatch must hold
//   retire_vld0/1  out  oldest / second-oldest entry retires this cycle
//   retire_idx0/1  out  head and head+1 (mod DEPTH)
//   head, tail     out  oldest occupied slot / next free slot
//   count          out  occupied entries, 0..DEPTH
//   empty, full    out  count==0 / count==DEPTH
// ---------------------------------------------------------------------------
module rob_retire_ctrl #(
   parameter int DEPTH = 64,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             alloc_req,
   input  logic [DEPTH-1:0] entry_complete,
   input  logic             retire_en,
   input  logic             flush,
   output logic             alloc_gnt,
   output logic [IDX_W-1:0] alloc_idx,
   output logic             stall,
   output logic             retire_vld0,
   output logic             retire_vld1,
   output logic [IDX_W-1:0] retire_idx0,
   output logic [IDX_W-1:0] retire_idx1,
   output logic [IDX_W-1:0] head,
   output logic [IDX_W-1:0] tail,
   output logic [IDX_W:0]   count,
   output logic             empty,
   output logic             full
);

   localparam logic ST_RUN   = 1'b0;
   localparam logic ST_FLUSH = 1'b1;

   localparam logic [IDX_W:0]   COUNT_MAX = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0]   COUNT_TWO = (IDX_W+1)'(2);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

   logic             state_q;
   logic             state_d;
   logic [IDX_W-1:0] head_q;
   logic [IDX_W-1:0] tail_q;
   logic [IDX_W:0]   count_q;

   logic             in_run;
   logic             flush_act;
   logic [IDX_W-1:0] head_p1;
   logic [1:0]       ret_n;
   logic [IDX_W-1:0] head_nxt;
   logic [IDX_W-1:0] tail_nxt;
   logic [IDX_W:0]   count_nxt;

   // -------------------------------------------------------------------------
   // Combinational status and control
   // -------------------------------------------------------------------------
   assign in_run = (state_q == ST_RUN);

   // Inputs are ignored while reset is held, so every combinational output
   // is qualified with rstn to keep its reset value independent of stimulus.
   assign flush_act = rstn & flush;

   assign empty = (count_q == '0);
   assign full  = (count_q == COUNT_MAX);

   assign stall = rstn & (full | ~in_run | flush_act);

   // Grant looks only at the registered count: a slot freed by retirement
   // this cycle is not reusable until the next cycle.
   assign alloc_gnt = rstn & alloc_req & ~stall;

   assign head_p1 = head_q + IDX_ONE;

   // The second slot can only retire behind the first, which keeps
   // retirement in order even when later flags are already set.
   assign retire_vld0 = rstn & in_run & ~flush_act & retire_en & ~empty
                        & entry_complete[head_q];
   assign retire_vld1 = retire_vld0 & (count_q >= COUNT_TWO)
                        & entry_complete[head_p1];

   assign ret_n = {1'b0, retire_vld0} + {1'b0, retire_vld1};

   assign head_nxt  = head_q + {{(IDX_W-2){1'b0}}, ret_n};
   assign tail_nxt  = tail_q + {{(IDX_W-1){1'b0}}, alloc_gnt};
   assign count_nxt = count_q + {{IDX_W{1'b0}}, alloc_gnt}
                              - {{(IDX_W-1){1'b0}}, ret_n};

   // FLUSH always lasts exactly one cycle.
   assign state_d = (in_run && flush) ? ST_FLUSH : ST_RUN;

   // -------------------------------------------------------------------------
   // State and pointer registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_RUN;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (flush || !in_run) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            head_q  <= head_nxt;
            tail_q  <= tail_nxt;
            count_q <= count_nxt;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Pointer outputs are shown regardless of grant/valid
   // -------------------------------------------------------------------------
   assign alloc_idx   = tail_q;
   assign retire_idx0 = head_q;
   assign retire_idx1 = head_p1;
   assign head        = head_q;
   assign tail        = tail_q;
   assign count       = count_q;

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rob_retire_ctrl
//   Directed bench for rob_retire_ctrl (DEPTH=64). Inputs are driven just
//   after the falling edge and outputs are sampled 1 time unit later, well
//   away from the rising edge that updates the DUT.
// ---------------------------------------------------------------------------
module tb_rob_retire_ctrl;

   localparam int DEPTH = 64;
   localparam int IDX_W = 6;

   logic             clk;
   logic             rstn;
   logic             alloc_req;
   logic [DEPTH-1:0] entry_complete;
   logic             retire_en;
   logic             flush;
   logic             alloc_gnt;
   logic [IDX_W-1:0] alloc_idx;
   logic             stall;
   logic             retire_vld0;
   logic             retire_vld1;
   logic [IDX_W-1:0] retire_idx0;
   logic [IDX_W-1:0] retire_idx1;
   logic [IDX_W-1:0] head;
   logic [IDX_W-1:0] tail;
   logic [IDX_W:0]   count;
   logic             empty;
   logic             full;

   int n_chk  = 0;
   int n_pass = 0;
   int bound_viol = 0;

   rob_retire_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .alloc_req      (alloc_req),
      .entry_complete (entry_complete),
      .retire_en      (retire_en),
      .flush          (flush),
      .alloc_gnt      (alloc_gnt),
      .alloc_idx      (alloc_idx),
      .stall          (stall),
      .retire_vld0    (retire_vld0),
      .retire_vld1    (retire_vld1),
      .retire_idx0    (retire_idx0),
      .retire_idx1    (retire_idx1),
      .head           (head),
      .tail           (tail),
      .count          (count),
      .empty          (empty),
      .full           (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Occupancy must stay within 0..DEPTH on every cycle.
   always @(negedge clk) begin
      if (rstn && (count > 7'(DEPTH))) bound_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rstn           = 1'b0;
      alloc_req      = 1'b1;
      entry_complete = '1;
      retire_en      = 1'b1;
      flush          = 1'b0;

      // ---------------- reset values, inputs active but ignored -------------
      settle();
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full",  32'(full),  0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_gnt",   32'(alloc_gnt), 0);
      chk("rst_vld0",  32'(retire_vld0), 0);
      tick();
      settle();
      chk("rst_hold_tail", 32'(tail), 0);
      chk("rst_hold_gnt",  32'(alloc_gnt), 0);

      // ---------------- fill 64 entries -------------------------------------
      rstn           = 1'b1;
      alloc_req      = 1'b1;
      entry_complete = '0;
      retire_en      = 1'b0;
      for (int i = 0; i < 64; i++) begin
         settle();
         chk("fill_gnt", 32'(alloc_gnt), 1);
         chk("fill_idx", 32'(alloc_idx), 32'(i));
         tick();
      end
      settle();
      chk("full_count", 32'(count), 64);
      chk("full_flag",  32'(full),  1);
      chk("full_stall", 32'(stall), 1);
      chk("full_gnt65", 32'(alloc_gnt), 0);
      tick();
      settle();
      chk("full_count_hold", 32'(count), 64);

      // ---------------- drain two per cycle ---------------------------------
      alloc_req      = 1'b0;
      entry_complete = '1;
      retire_en      = 1'b1;
      for (int i = 0; i < 32; i++) begin
         settle();
         chk("drain_vld0", 32'(retire_vld0), 1);
         chk("drain_vld1", 32'(retire_vld1), 1);
         chk("drain_idx0", 32'(retire_idx0), 32'(2*i));
         chk("drain_idx1", 32'(retire_idx1), 32'(2*i+1));
         tick();
      end
      settle();
      chk("drain_empty", 32'(empty), 1);
      chk("drain_head",  32'(head),  0);
      chk("drain_tail",  32'(tail),  0);

      // ---------------- in-order blocking at head=5 -------------------------
      alloc_req      = 1'b1;
      entry_complete = '0;
      retire_en      = 1'b0;
      repeat (8) tick();
      alloc_req      = 1'b0;
      retire_en      = 1'b1;
      entry_complete = 64'h1F;      // slots 0..4 only
      repeat (3) tick();            // heads 0 -> 2 -> 4 -> 5
      settle();
      chk("blk_head",  32'(head),  5);
      chk("blk_count", 32'(count), 3);
      entry_complete = 64'h40;      // [5]=0, [6]=1
      settle();
      chk("blk_vld0", 32'(retire_vld0), 0);
      chk("blk_vld1", 32'(retire_vld1), 0);
      tick();
      settle();
      chk("blk_head_hold", 32'(head), 5);
      entry_complete = 64'h60;      // [5]=1, [6]=1
      settle();
      chk("unblk_vld0", 32'(retire_vld0), 1);
      chk("unblk_vld1", 32'(retire_vld1), 1);
      tick();
      settle();
      chk("unblk_head",  32'(head),  7);
      chk("unblk_count", 32'(count), 1);

      // ---------------- wrap at head=63 -------------------------------------
      entry_complete = '1;
      tick();                       // slot 7 retires: head=8, tail=8, empty
      alloc_req      = 1'b1;
      entry_complete = '0;
      retire_en      = 1'b0;
      repeat (55) tick();           // tail=63, count=55
      alloc_req      = 1'b0;
      entry_complete = '1;
      retire_en      = 1'b1;
      repeat (28) tick();           // 27 double retires then one single
      settle();
      chk("pre_wrap_head",  32'(head),  63);
      chk("pre_wrap_count", 32'(count), 0);
      alloc_req      = 1'b1;
      entry_complete = '0;
      retire_en      = 1'b0;
      repeat (2) tick();
      settle();
      chk("wrap_tail",  32'(tail),  1);
      chk("wrap_count", 32'(count), 2);
      alloc_req      = 1'b0;
      entry_complete = '1;
      retire_en      = 1'b1;
      settle();
      chk("wrap_idx0", 32'(retire_idx0), 63);
      chk("wrap_idx1", 32'(retire_idx1), 0);
      chk("wrap_vld1", 32'(retire_vld1), 1);
      tick();
      settle();
      chk("wrap_head",  32'(head),  1);
      chk("wrap_empty", 32'(empty), 1);

      // ---------------- flush at count=10 -----------------------------------
      alloc_req      = 1'b1;
      entry_complete = '0;
      retire_en      = 1'b0;
      repeat (10) tick();
      settle();
      chk("pre_flush_count", 32'(count), 10);
      entry_complete = '1;
      retire_en      = 1'b1;
      flush          = 1'b1;
      settle();
      chk("flush_gnt",   32'(alloc_gnt), 0);
      chk("flush_vld0",  32'(retire_vld0), 0);
      chk("flush_stall", 32'(stall), 1);
      tick();
      flush = 1'b0;
      settle();
      chk("fst_count", 32'(count), 0);
      chk("fst_head",  32'(head),  0);
      chk("fst_tail",  32'(tail),  0);
      chk("fst_stall", 32'(stall), 1);
      chk("fst_gnt",   32'(alloc_gnt), 0);
      chk("fst_vld0",  32'(retire_vld0), 0);
      tick();
      settle();
      chk("resume_stall", 32'(stall), 0);
      chk("resume_gnt",   32'(alloc_gnt), 1);
      chk("resume_idx",   32'(alloc_idx), 0);
      tick();
      alloc_req = 1'b0;
      settle();
      // slot granted at the previous edge may retire in this cycle
      chk("early_ret_vld0", 32'(retire_vld0), 1);
      chk("early_ret_idx0", 32'(retire_idx0), 0);
      chk("early_ret_vld1", 32'(retire_vld1), 0);
      tick();
      settle();
      chk("early_ret_empty", 32'(empty), 1);

      // ---------------- alloc + 2-wide retire at count=63 -------------------
      alloc_req      = 1'b1;
      entry_complete = '0;
      retire_en      = 1'b0;
      repeat (63) tick();
      settle();
      chk("c63_count", 32'(count), 63);
      entry_complete = '1;
      retire_en      = 1'b1;
      settle();
      chk("c63_gnt",  32'(alloc_gnt), 1);
      chk("c63_vld1", 32'(retire_vld1), 1);
      tick();
      settle();
      chk("c63_after", 32'(count), 62);

      // full plus same-cycle retire: retirement frees nothing for grant
      retire_en = 1'b0;
      repeat (2) tick();
      settle();
      chk("c64_count", 32'(count), 64);
      retire_en = 1'b1;
      settle();
      chk("c64_gnt",  32'(alloc_gnt), 0);
      chk("c64_vld1", 32'(retire_vld1), 1);
      tick();
      settle();
      chk("c64_after", 32'(count), 62);

      // ---------------- async reset at count=20 -----------------------------
      alloc_req = 1'b0;
      repeat (21) tick();
      settle();
      chk("pre_rst_count", 32'(count), 20);
      chk("pre_rst_vld0",  32'(retire_vld0), 1);
      alloc_req = 1'b1;
      #1;
      rstn = 1'b0;                  // mid-low phase, no clock edge nearby
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_vld0",  32'(retire_vld0), 0);
      chk("arst_empty", 32'(empty), 1);
      chk("arst_gnt",   32'(alloc_gnt), 0);
      chk("arst_head",  32'(head), 0);
      tick();
      rstn = 1'b1;
      settle();
      chk("post_rst_gnt", 32'(alloc_gnt), 1);
      chk("post_rst_idx", 32'(alloc_idx), 0);
      tick();
      settle();
      chk("post_rst_count", 32'(count), 1);

      chk("count_bound", 32'(bound_viol), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
